npc_dual_port_mem_ctrl: RTL and testbench

- Unified memory controller for the single-cycle RV32 core.
- Port 1: instruction-fetch, read-only, one word.
- Port 2: data load/store with a byte-size mask.
- Backed by an internal word-organised RAM mapped at MEM_BASE. Reads are combinational; writes are synchronous.

---
 rtl/npc_dual_port_mem_ctrl_if.sv | 35 +++
 rtl/npc_dual_port_mem_ctrl.sv | 90 +++++++++
 tb/tb_npc_dual_port_mem_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/npc_dual_port_mem_ctrl_if.sv
// Bus bundle for the unified fetch/load-store memory controller.
// The master modport is the core side; the slave modport is the controller side.
interface npc_dual_port_mem_ctrl_if #(
  parameter int unsigned ISA_WIDTH  = 32,
  parameter int unsigned MASK_WIDTH = 4
);
  logic [ISA_WIDTH-1:0]  mem_1_addr;
  logic                  mem_1_r_en;
  logic [ISA_WIDTH-1:0]  mem_1_r;
  logic                  mem_1_err;
  logic                  mem_1_misalign;

  logic [ISA_WIDTH-1:0]  mem_2_addr;
  logic                  mem_2_r_en;
  logic                  mem_2_w_en;
  logic [ISA_WIDTH-1:0]  mem_2_w;
  logic [MASK_WIDTH-1:0] mem_2_mask;
  logic [ISA_WIDTH-1:0]  mem_2_r;
  logic                  mem_2_err;
  logic                  mem_2_misalign;

  modport master (
    output mem_1_addr, mem_1_r_en,
    output mem_2_addr, mem_2_r_en, mem_2_w_en, mem_2_w, mem_2_mask,
    input  mem_1_r, mem_1_err, mem_1_misalign,
    input  mem_2_r, mem_2_err, mem_2_misalign
  );

  modport slave (
    input  mem_1_addr, mem_1_r_en,
    input  mem_2_addr, mem_2_r_en, mem_2_w_en, mem_2_w, mem_2_mask,
    output mem_1_r, mem_1_err, mem_1_misalign,
    output mem_2_r, mem_2_err, mem_2_misalign
  );
endinterface

// File: rtl/npc_dual_port_mem_ctrl.sv
// Unified memory controller: combinational fetch and load ports, synchronous byte-masked store.
// Optional alignment checking is enabled by defining MEM_CTRL_ALIGN_CHECK_EN.
module npc_dual_port_mem_ctrl #(
  parameter int unsigned          ISA_WIDTH  = 32,
  parameter int unsigned          MASK_WIDTH = 4,
  parameter logic [ISA_WIDTH-1:0] MEM_BASE   = 32'h8000_0000,
  parameter int unsigned          MEM_DEPTH  = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  npc_dual_port_mem_ctrl_if.slave  bus
);
  localparam int unsigned          OFF_W     = $clog2(MASK_WIDTH);
  localparam int unsigned          IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ISA_WIDTH-1:0] MEM_BYTES = ISA_WIDTH'(MEM_DEPTH * MASK_WIDTH);

  logic [ISA_WIDTH-1:0] ram [MEM_DEPTH];

  logic [ISA_WIDTH-1:0]  rel_1, rel_2;
  logic                  in_1, in_2;
  logic [IDX_W-1:0]      idx_1, idx_2;
  logic [OFF_W-1:0]      off_1, off_2;
  logic [ISA_WIDTH-1:0]  word_1, word_2;
  logic [ISA_WIDTH-1:0]  lane_2;
  logic [MASK_WIDTH-1:0] wr_mask;
  logic [ISA_WIDTH-1:0]  wr_data;
  logic                  wr_go;
  logic                  mis_1, mis_2;

  // Range test on the rebased offset keeps MEM_BASE + size from overflowing.
  assign rel_1 = bus.mem_1_addr - MEM_BASE;
  assign rel_2 = bus.mem_2_addr - MEM_BASE;
  assign in_1  = (bus.mem_1_addr >= MEM_BASE) && (rel_1 < MEM_BYTES);
  assign in_2  = (bus.mem_2_addr >= MEM_BASE) && (rel_2 < MEM_BYTES);
  assign idx_1 = rel_1[IDX_W+OFF_W-1:OFF_W];
  assign idx_2 = rel_2[IDX_W+OFF_W-1:OFF_W];
  assign off_1 = bus.mem_1_addr[OFF_W-1:0];
  assign off_2 = bus.mem_2_addr[OFF_W-1:0];

  assign word_1 = ram[idx_1] >> {off_1, 3'b000};
  assign word_2 = ram[idx_2] >> {off_2, 3'b000};

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign mis_1 = rst & bus.mem_1_r_en & (off_1 != '0);
  assign mis_2 = rst & (bus.mem_2_r_en | bus.mem_2_w_en) &
                 (((bus.mem_2_mask == MASK_WIDTH'(2'b11)) & bus.mem_2_addr[0]) |
                  ((bus.mem_2_mask == '1) & (off_2 != '0)));
`else
  assign mis_1 = 1'b0;
  assign mis_2 = 1'b0;
`endif

  assign bus.mem_1_misalign = mis_1;
  assign bus.mem_2_misalign = mis_2;

  always_comb begin
    lane_2 = '0;
    for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
      lane_2[8*i +: 8] = {8{bus.mem_2_mask[i]}};
    end
  end

  always_comb begin
    bus.mem_1_r   = '0;
    bus.mem_2_r   = '0;
    bus.mem_1_err = rst & bus.mem_1_r_en & ~in_1;
    bus.mem_2_err = rst & (bus.mem_2_r_en | bus.mem_2_w_en) & ~in_2;
    if (rst && bus.mem_1_r_en && in_1 && !mis_1) begin
      bus.mem_1_r = word_1;
    end
    if (rst && bus.mem_2_r_en && in_2 && !mis_2) begin
      bus.mem_2_r = word_2 & lane_2;
    end
  end

  // Shifting left and truncating drops lanes that would spill into the next word.
  assign wr_mask = MASK_WIDTH'(bus.mem_2_mask << off_2);
  assign wr_data = ISA_WIDTH'(bus.mem_2_w << {off_2, 3'b000});
  assign wr_go   = rst & bus.mem_2_w_en & in_2 & ~mis_2;

  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
        if (wr_mask[i]) begin
          ram[idx_2][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_npc_dual_port_mem_ctrl.sv
// Scoreboard bench for npc_dual_port_mem_ctrl: expectations are queued with the stimulus
// and drained against the combinational outputs before the next clock edge.
module tb_npc_dual_port_mem_ctrl;
  localparam int SEL_R1 = 0, SEL_E1 = 1, SEL_R2 = 2, SEL_E2 = 3, SEL_M1 = 4, SEL_M2 = 5;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
  localparam logic ALIGN = 1'b1;
`else
  localparam logic ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  string       tag_q[$];
  int          sel_q[$];
  logic [31:0] exp_q[$];

  npc_dual_port_mem_ctrl_if #(.ISA_WIDTH(32), .MASK_WIDTH(4)) bus ();

  npc_dual_port_mem_ctrl #(
    .ISA_WIDTH (32),
    .MASK_WIDTH(4),
    .MEM_BASE  (32'h8000_0000),
    .MEM_DEPTH (4096)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(exp);
  endtask

  task automatic drain();
    logic [31:0] obs;
    #2;
    while (exp_q.size() > 0) begin
      case (sel_q[0])
        SEL_R1:  obs = bus.mem_1_r;
        SEL_E1:  obs = {31'd0, bus.mem_1_err};
        SEL_R2:  obs = bus.mem_2_r;
        SEL_E2:  obs = {31'd0, bus.mem_2_err};
        SEL_M1:  obs = {31'd0, bus.mem_1_misalign};
        default: obs = {31'd0, bus.mem_2_misalign};
      endcase
      check_val(tag_q.pop_front(), obs, exp_q.pop_front());
      void'(sel_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input logic [31:0] addr, input logic en);
    bus.mem_1_addr = addr;
    bus.mem_1_r_en = en;
  endtask

  task automatic set2(input logic [31:0] addr, input logic r, input logic w,
                      input logic [31:0] data, input logic [3:0] mask);
    bus.mem_2_addr = addr;
    bus.mem_2_r_en = r;
    bus.mem_2_w_en = w;
    bus.mem_2_w    = data;
    bus.mem_2_mask = mask;
  endtask

  task automatic idle();
    set1(32'h8000_0000, 1'b0);
    set2(32'h8000_0000, 1'b0, 1'b0, 32'h0, 4'b0000);
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    idle();
    set2(addr, 1'b0, 1'b1, data, mask);
    tick();
    idle();
  endtask

  initial begin
    idle();
    tick();
    tick();

    // seed a known word so the reset hold can prove the write was blocked
    rst = 1'b1;
    write_word(32'h8000_0000, 32'h1111_1111, 4'b1111);

    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set1(i == 0 ? 32'h8000_0000 : 32'h7FFF_FFFC, 1'b1);
      set2(32'h8000_0000, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'b1111);
      push("rst_r1", SEL_R1, 32'h0);
      push("rst_e1", SEL_E1, 32'h0);
      push("rst_r2", SEL_R2, 32'h0);
      push("rst_e2", SEL_E2, 32'h0);
      push("rst_m1", SEL_M1, 32'h0);
      push("rst_m2", SEL_M2, 32'h0);
      drain();
      tick();
    end
    rst = 1'b1;
    idle();
    set1(32'h8000_0000, 1'b1);
    set2(32'h8000_0000, 1'b1, 1'b0, 32'h0, 4'b1111);
    push("post_rst_r1", SEL_R1, 32'h1111_1111);
    push("post_rst_r2", SEL_R2, 32'h1111_1111);
    drain();

    write_word(32'h8000_0010, 32'h1234_5678, 4'b1111);
    set1(32'h8000_0010, 1'b1);
    set2(32'h8000_0010, 1'b1, 1'b0, 32'h0, 4'b1111);
    push("word_r1", SEL_R1, 32'h1234_5678);
    push("word_e1", SEL_E1, 32'h0);
    push("word_r2", SEL_R2, 32'h1234_5678);
    push("word_e2", SEL_E2, 32'h0);
    drain();
    set2(32'h8000_0010, 1'b0, 1'b0, 32'h0, 4'b1111);
    push("r2_no_en", SEL_R2, 32'h0);
    drain();

    write_word(32'h8000_0013, 32'h0000_00AA, 4'b0001);
    write_word(32'h8000_0010, 32'h0000_BBCC, 4'b0011);
    write_word(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000);
    set1(32'h8000_0010, 1'b1);
    set2(32'h8000_0010, 1'b1, 1'b0, 32'h0, 4'b1111);
    push("lane_word_r1", SEL_R1, 32'hAA34_BBCC);
    push("lane_word_r2", SEL_R2, 32'hAA34_BBCC);
    drain();
    set1(32'h8000_0012, 1'b1);
    set2(32'h8000_0013, 1'b1, 1'b0, 32'h0, 4'b0001);
    push("fetch_off2", SEL_R1, 32'h0000_AA34);
    push("byte_rd", SEL_R2, 32'h0000_00AA);
    drain();
    set2(32'h8000_0012, 1'b1, 1'b0, 32'h0, 4'b0011);
    push("half_rd", SEL_R2, 32'h0000_AA34);
    drain();

    write_word(32'h8000_0020, 32'h0102_0304, 4'b1111);
    set1(32'h8000_0020, 1'b1);
    set2(32'h8000_0020, 1'b1, 1'b1, 32'hCAFE_F00D, 4'b1111);
    push("coll_old_r1", SEL_R1, 32'h0102_0304);
    push("coll_old_r2", SEL_R2, 32'h0102_0304);
    drain();
    tick();
    set2(32'h8000_0020, 1'b0, 1'b0, 32'h0, 4'b1111);
    push("coll_new_r1", SEL_R1, 32'hCAFE_F00D);
    drain();

    write_word(32'h8000_3FFC, 32'h7766_5544, 4'b1111);
    set1(32'h8000_3FFC, 1'b1);
    push("top_word_r1", SEL_R1, 32'h7766_5544);
    push("top_word_e1", SEL_E1, 32'h0);
    drain();
    set1(32'h7FFF_FFFC, 1'b1);
    set2(32'h8000_4000, 1'b1, 1'b1, 32'h5555_5555, 4'b1111);
    push("oor_r1", SEL_R1, 32'h0);
    push("oor_e1", SEL_E1, 32'h1);
    push("oor_r2", SEL_R2, 32'h0);
    push("oor_e2", SEL_E2, 32'h1);
    drain();
    tick();
    set2(32'h8000_4000, 1'b0, 1'b1, 32'h5555_5555, 4'b1111);
    push("oor_wr_e2", SEL_E2, 32'h1);
    drain();
    tick();
    idle();
    set1(32'h8000_0000, 1'b1);
    set2(32'h8000_3FFC, 1'b1, 1'b0, 32'h0, 4'b1111);
    push("oor_no_alias", SEL_R1, 32'h1111_1111);
    push("oor_top_kept", SEL_R2, 32'h7766_5544);
    drain();

    write_word(32'h8000_0030, 32'h0000_0000, 4'b1111);
    set1(32'h8000_0002, 1'b1);
    set2(32'h8000_0031, 1'b1, 1'b1, 32'hA1B2_C3D4, 4'b1111);
    push("mis_fetch_r1", SEL_R1, ALIGN ? 32'h0 : 32'h0000_1111);
    push("mis_fetch_m1", SEL_M1, {31'd0, ALIGN});
    push("mis_store_m2", SEL_M2, {31'd0, ALIGN});
    push("mis_store_e2", SEL_E2, 32'h0);
    drain();
    tick();
    idle();
    set2(32'h8000_0030, 1'b1, 1'b0, 32'h0, 4'b1111);
    push("mis_store_ram", SEL_R2, ALIGN ? 32'h0 : 32'hB2C3_D400);
    push("aligned_m2", SEL_M2, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
